pe_fc_seq: RTL and testbench

Sequencer for a single 1x3 floating-point PE (3 multipliers → 3-input adder → bias adder). It accepts a job of N beats, where one beat is one data/kernel triplet plus bias. It admits beats through a valid/ready handshake and drives the PE's four stage-enable strobes so that every admitted beat flows through the 4-stage PE pipeline. It also produces output-valid, output-index and done signals for the FC result writer.

---
 rtl/pe_fc_seq.sv | 110 +++++++++++
 tb/tb_pe_fc_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pe_fc_seq.sv
// Beat sequencer for a 1x3 floating-point PE: admits N beats via valid/ready,
// drives the four PE stage strobes and flags each result with its index.
module pe_fc_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] beat_num,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pe_on_3mul_pe_en,
    output logic             pe_on_align3,
    output logic             pe_on_sum3,
    output logic             pe_on_bias,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_num_q, beat_num_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] out_idx_q, out_idx_d;
    logic [3:0]       v_q, v_d;
    logic             admit_c;
    logic             last_c;

    assign admit_c = in_valid && (state_q == RUN);
    // Final result of the job: flagged output carrying index N-1 while draining
    assign last_c  = (state_q == DRAIN) && v_q[3] &&
                     (out_idx_q == (beat_num_q - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_num_q  <= '0;
            issue_cnt_q <= '0;
            out_idx_q   <= '0;
            v_q         <= '0;
        end else begin
            state_q     <= state_d;
            beat_num_q  <= beat_num_d;
            issue_cnt_q <= issue_cnt_d;
            out_idx_q   <= out_idx_d;
            v_q         <= v_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_num_d  = beat_num_q;
        issue_cnt_d = issue_cnt_q;
        out_idx_d   = out_idx_q;
        v_d         = {v_q[2:0], admit_c};

        if (v_q[3]) begin
            out_idx_d = out_idx_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    beat_num_d  = beat_num;
                    issue_cnt_d = '0;
                    out_idx_d   = '0;
                    state_d     = (beat_num == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (admit_c) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    if (issue_cnt_q == (beat_num_q - CNT_W'(1))) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_c) begin
                    state_d = IDLE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy             = (state_q != IDLE);
    assign done             = last_c || (state_q == FIN);
    assign in_ready         = (state_q == RUN);
    assign pe_on_3mul_pe_en = admit_c;
    assign pe_on_align3     = v_q[0];
    assign pe_on_sum3       = v_q[1];
    assign pe_on_bias       = v_q[2];
    assign out_valid        = v_q[3];
    assign out_idx          = out_idx_q;

endmodule

// File: tb/tb_pe_fc_seq.sv
// Directed bench for pe_fc_seq: per-cycle bit masks (bit k = cycle k after
// the start cycle) give the expected handshake, strobes, done and busy.
module tb_pe_fc_seq;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] beat_num;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic             mul_en;
    logic             align3;
    logic             sum3;
    logic             bias;
    logic             out_valid;
    logic [CNT_W-1:0] out_idx;

    int errs   = 0;
    int checks = 0;

    pe_fc_seq #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .beat_num         (beat_num),
        .busy             (busy),
        .done             (done),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .pe_on_3mul_pe_en (mul_en),
        .pe_on_align3     (align3),
        .pe_on_sum3       (sum3),
        .pe_on_bias       (bias),
        .out_valid        (out_valid),
        .out_idx          (out_idx)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs_vec();
        return {busy, done, in_ready, mul_en, align3, sum3, bias, out_valid};
    endfunction

    // em = {busy, done, in_ready, mul, align3, sum3, bias, out_valid} masks.
    // Entered and left at posedge+1; beat_num shows bn only in cycle 0.
    task automatic run_seq(input string name, input int n_cyc,
                           input logic [CNT_W-1:0] bn, input logic [31:0] smask,
                           input logic [31:0] vmask, input logic [7:0][31:0] em);
        int         idx;
        logic [7:0] exp_v;
        idx = 0;
        for (int k = 0; k < n_cyc; k++) begin
            start    = smask[k];
            beat_num = (k == 0) ? bn : CNT_W'(9);
            in_valid = vmask[k];
            @(negedge clk);
            for (int i = 0; i < 8; i++) exp_v[i] = em[i][k];
            chk_eq($sformatf("%s_c%0d", name, k), 32'(obs_vec()), 32'(exp_v));
            if (exp_v[0]) begin
                chk_eq($sformatf("%s_idx%0d", name, idx), 32'(out_idx), 32'(idx));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        beat_num = '0;
        in_valid = 1'b0;
        #12;
        chk_eq("reset_out", 32'(obs_vec()), 32'h0);
        chk_eq("reset_idx", 32'(out_idx), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // N=5 contiguous
        run_seq("contig5", 12, 4'd5, 32'h1, 32'hFFFF_FFFF,
                {32'h3FE, 32'h200, 32'h3E, 32'h3E, 32'h7C, 32'hF8, 32'h1F0, 32'h3E0});

        // N=3 with bubbles 1,0,0,1,1; in_valid also high in IDLE and DRAIN
        run_seq("bubble3", 12, 4'd3, 32'h1, 32'hF3,
                {32'h3FE, 32'h200, 32'h3E, 32'h32, 32'h64, 32'hC8, 32'h190, 32'h320});

        // N=0: one FIN cycle with done, no strobes
        run_seq("zero", 4, 4'd0, 32'h1, 32'h6,
                {32'h2, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});

        // N=4 with a second start (beat_num=9) in cycle 3 that must be ignored
        run_seq("ignstart", 11, 4'd4, 32'h9, 32'hFFFF_FFFF,
                {32'h1FE, 32'h100, 32'h1E, 32'h1E, 32'h3C, 32'h78, 32'hF0, 32'h1E0});

        // Maximum job for CNT_W=4
        run_seq("max15", 22, 4'd15, 32'h1, 32'hFFFF_FFFF,
                {32'hFFFFE, 32'h80000, 32'hFFFE, 32'hFFFE, 32'h1FFFC, 32'h3FFF8,
                 32'h7FFF0, 32'hFFFE0});

        // Reset mid-run after three admits
        run_seq("prerst", 4, 4'd5, 32'h1, 32'hFFFF_FFFF,
                {32'h3FE, 32'h200, 32'h3E, 32'h3E, 32'h7C, 32'hF8, 32'h1F0, 32'h3E0});
        in_valid = 1'b1;
        #1;
        chk_eq("rst_pre_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk_eq("rst_async_out", 32'(obs_vec()), 32'h0);
        chk_eq("rst_async_idx", 32'(out_idx), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_seq("postrst", 8, 4'd0, 32'h0, 32'hFFFF_FFFF,
                {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0});
        run_seq("after3", 10, 4'd3, 32'h1, 32'hFFFF_FFFF,
                {32'hFE, 32'h80, 32'hE, 32'hE, 32'h1C, 32'h38, 32'h70, 32'hE0});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
